// File: rtl/blk8x8_pingpong_out.sv
// Ping-pong capture of 8x8 pixel blocks with framed valid/ready replay.
// Optional build macro BLK8_TRANSPOSE_EN replays each block column-major.
module blk8x8_pingpong_out #(
    parameter int DW        = 8,
    parameter int BLK_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DW-1:0]        data_in,
    input  logic                 de_in,
    output logic [DW-1:0]        m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_sob,
    output logic                 m_eob,
    output logic                 m_sol,
    output logic                 m_eol,
    output logic                 overflow,
    output logic [BLK_CNT_W-1:0] blk_cnt
);

    typedef enum logic {
        WR_WRITE,
        WR_DROP
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_PRIME,
        RD_STREAM
    } rd_state_t;

    logic [DW-1:0] mem [0:127];

    wr_state_t wr_state;
    rd_state_t rd_state;
    logic [5:0] wr_idx;
    logic       wr_bank;
    logic [1:0] full;
    logic       rd_bank;
    logic       other_bank;
    logic [5:0] out_idx;

    logic       hs;
    logic       last_hs;
    logic       bank_busy;
    logic       wr_en;
    logic       rd_sel_bank;
    logic [5:0] rd_idx;
    logic [6:0] rd_addr;

    assign hs         = m_valid && m_ready;
    assign last_hs    = hs && (out_idx == 6'd63);
    assign other_bank = ~rd_bank;

    // A bank released on this very edge is free for a block starting on it.
    assign bank_busy = full[wr_bank] && !(last_hs && (rd_bank == wr_bank));
    assign wr_en     = de_in && (wr_state == WR_WRITE) &&
                       !((wr_idx == 6'd0) && bank_busy);

    // Address of the pixel the output register loads on its next update.
    always_comb begin
        rd_sel_bank = rd_bank;
        rd_idx      = 6'd0;
        if (rd_state == RD_STREAM) begin
            if (out_idx == 6'd63) begin
                rd_sel_bank = other_bank;
            end else begin
                rd_idx = out_idx + 6'd1;
            end
        end
    end

`ifdef BLK8_TRANSPOSE_EN
    assign rd_addr = {rd_sel_bank, rd_idx[2:0], rd_idx[5:3]};
`else
    assign rd_addr = {rd_sel_bank, rd_idx};
`endif

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_idx}] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state <= WR_WRITE;
            wr_idx   <= 6'd0;
            wr_bank  <= 1'b0;
            full     <= 2'b00;
            overflow <= 1'b0;
        end else begin
            if (last_hs) begin
                full[rd_bank] <= 1'b0;
            end
            if (wr_en && (wr_idx == 6'd63)) begin
                full[wr_bank] <= 1'b1;
            end
            case (wr_state)
                WR_WRITE: begin
                    if (de_in) begin
                        if ((wr_idx == 6'd0) && bank_busy) begin
                            wr_state <= WR_DROP;
                            overflow <= 1'b1;
                            wr_idx   <= 6'd1;
                        end else begin
                            wr_idx <= wr_idx + 6'd1;
                            if (wr_idx == 6'd63) begin
                                wr_bank <= ~wr_bank;
                            end
                        end
                    end
                end
                WR_DROP: begin
                    if (de_in) begin
                        wr_idx <= wr_idx + 6'd1;
                        if (wr_idx == 6'd63) begin
                            wr_state <= WR_WRITE;
                        end
                    end
                end
                default: wr_state <= WR_WRITE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= RD_IDLE;
            rd_bank  <= 1'b0;
            out_idx  <= 6'd0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            blk_cnt  <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (full[rd_bank]) begin
                        rd_state <= RD_PRIME;
                    end
                end
                RD_PRIME: begin
                    rd_state <= RD_STREAM;
                    m_valid  <= 1'b1;
                    m_data   <= mem[rd_addr];
                    out_idx  <= 6'd0;
                end
                RD_STREAM: begin
                    if (hs) begin
                        if (out_idx == 6'd63) begin
                            rd_bank <= other_bank;
                            blk_cnt <= blk_cnt + BLK_CNT_W'(1);
                            out_idx <= 6'd0;
                            if (full[other_bank]) begin
                                m_data <= mem[rd_addr];
                            end else begin
                                m_valid  <= 1'b0;
                                rd_state <= RD_IDLE;
                            end
                        end else begin
                            out_idx <= out_idx + 6'd1;
                            m_data  <= mem[rd_addr];
                        end
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    assign m_sob = m_valid && (out_idx == 6'd0);
    assign m_eob = m_valid && (out_idx == 6'd63);
    assign m_sol = m_valid && (out_idx[2:0] == 3'd0);
    assign m_eol = m_valid && (out_idx[2:0] == 3'd7);

endmodule

// File: tb/tb_blk8x8_pingpong_out.sv
// Directed and randomized bench for blk8x8_pingpong_out against a queue-based block model.
`timescale 1ns/1ps
module tb_blk8x8_pingpong_out;
    localparam int DW = 8;
    localparam int BW = 16;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          de_in   = 1'b0;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_valid, m_sob, m_eob, m_sol, m_eol, overflow;
    logic [BW-1:0] blk_cnt;

    int vectors     = 0;
    int miscompares = 0;
    logic [DW-1:0] exp_q [$];
    int  out_cnt   = 0;
    int  mon_k     = 0;
    bit  rdy_rand  = 1'b0;
    bit  prev_stall = 1'b0;
    logic [DW+3:0] prev_word = '0;

    always #5 clk = ~clk;

    blk8x8_pingpong_out #(.DW(DW), .BLK_CNT_W(BW)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .de_in(de_in),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_sob(m_sob), .m_eob(m_eob), .m_sol(m_sol), .m_eol(m_eol),
        .overflow(overflow), .blk_cnt(blk_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Output position k carries stored pixel perm(k).
    function automatic int perm(input int k);
`ifdef BLK8_TRANSPOSE_EN
        return (k % 8) * 8 + k / 8;
`else
        return k;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
        if (rdy_rand) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_block(input int base, input bit keep, input int gap_pct, input bit chk_ovf);
        if (keep)
            for (int k = 0; k < 64; k++) exp_q.push_back(DW'(base + perm(k)));
        for (int i = 0; i < 64; i++) begin
            while (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
                de_in = 1'b0;
                tick();
            end
            de_in   = 1'b1;
            data_in = DW'(base + i);
            tick();
            if (i == 0 && chk_ovf) begin
                #1;
                chk("overflow_on_drop", 32'(overflow), 32'd1);
            end
        end
        de_in = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        chk("drain_done", 32'(exp_q.size()), 32'd0);
        tick();
        tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, 32'({m_valid, m_sob, m_eob, m_sol, m_eol, overflow}), 32'd0);
        chk(tag, 32'(m_data), 32'd0);
        chk(tag, 32'(blk_cnt), 32'd0);
    endtask

    always @(posedge clk) begin
        #4;
        if (!rst_n) begin
            out_cnt    = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", 32'({m_valid, m_data, m_sob, m_eob, m_sol, m_eol}),
                    32'({1'b1, prev_word}));
            if (m_valid && m_ready) begin
                mon_k = out_cnt % 64;
                chk("pixel_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) chk("pixel_data", 32'(m_data), 32'(exp_q.pop_front()));
                chk("markers", 32'({m_sob, m_eob, m_sol, m_eol}),
                    32'({mon_k == 0, mon_k == 63, (mon_k % 8) == 0, (mon_k % 8) == 7}));
                out_cnt++;
            end else if (!m_valid) begin
                chk("idle_markers", 32'({m_sob, m_eob, m_sol, m_eol}), 32'd0);
            end
            prev_stall = m_valid && !m_ready;
            prev_word  = {m_data, m_sob, m_eob, m_sol, m_eol};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        tick();
        tick();
        chk_reset_outputs("reset_held");
        rst_n   = 1'b1;
        m_ready = 1'b1;
        tick();
        chk_reset_outputs("reset_released");

        // Single block, no backpressure, latency after last write
        send_block(0, 1'b1, 0, 1'b0);
        #1;
        chk("latency_n", 32'(m_valid), 32'd0);
        tick();
        #1;
        chk("latency_n1", 32'(m_valid), 32'd0);
        tick();
        #1;
        chk("latency_n2_valid", 32'(m_valid), 32'd1);
        chk("latency_n2_data", 32'(m_data), 32'(perm(0)));
        chk("latency_n2_sob", 32'(m_sob), 32'd1);
        drain(500);
        chk("blk_cnt_single", 32'(blk_cnt), 32'd1);
        chk("overflow_single", 32'(overflow), 32'd0);

        // Random backpressure over 3 blocks, gapped input, at most two blocks in flight
        rdy_rand = 1'b1;
        for (int b = 0; b < 3; b++) begin
            n = 0;
            while (exp_q.size() > 64 && n < 3000) begin
                tick();
                n++;
            end
            chk("flow_wait", 32'(exp_q.size() <= 64), 32'd1);
            send_block(64 * b, 1'b1, 20, 1'b0);
        end
        drain(3000);
        rdy_rand = 1'b0;
        m_ready  = 1'b1;
        chk("blk_cnt_bp", 32'(blk_cnt), 32'd4);
        chk("overflow_bp", 32'(overflow), 32'd0);

        // Third block starts on the edge that releases the first block's bank
        send_block(10, 1'b1, 0, 1'b0);
        send_block(80, 1'b1, 0, 1'b0);
        tick();
        send_block(150, 1'b1, 0, 1'b0);
        chk("overflow_coincide", 32'(overflow), 32'd0);
        drain(1000);
        chk("blk_cnt_coincide", 32'(blk_cnt), 32'd7);

        // Overflow: consumer stalled, third block dropped whole
        m_ready = 1'b0;
        send_block(20, 1'b1, 0, 1'b0);
        send_block(90, 1'b1, 0, 1'b0);
        chk("overflow_before_drop", 32'(overflow), 32'd0);
        send_block(160, 1'b0, 0, 1'b1);
        chk("overflow_sticky", 32'(overflow), 32'd1);
        m_ready = 1'b1;
        drain(1000);
        chk("blk_cnt_after_drop", 32'(blk_cnt), 32'd9);
        send_block(30, 1'b1, 0, 1'b0);
        drain(1000);
        chk("blk_cnt_after_recover", 32'(blk_cnt), 32'd10);
        chk("overflow_still_set", 32'(overflow), 32'd1);

        // Reset in the middle of a block
        for (int i = 0; i < 30; i++) begin
            de_in   = 1'b1;
            data_in = DW'(200 + i);
            tick();
        end
        de_in = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("reset_mid_block");
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("no_output_after_reset", 32'(m_valid), 32'd0);
        chk_reset_outputs("reset_quiet");
        send_block(40, 1'b1, 0, 1'b0);
        drain(500);
        chk("blk_cnt_post_reset", 32'(blk_cnt), 32'd1);
        chk("overflow_post_reset", 32'(overflow), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
